// File: rtl/ldpc_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ldpc_enc_pkg
// Purpose : Shared FSM encodings, status codes and the WiMax reference
//           lifting size for the QC-LDPC encoder.
// Revision: 1.0 - initial release
// ============================================================================
package ldpc_enc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PAR0 = 3'd2,
        S_PARI = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_PAR  = 2'b10;
    localparam logic [1:0] ST_OUT  = 2'b11;

    // Base-matrix shifts are tabulated for Z0 = 96 in the WiMax tables.
    localparam int Z0 = 96;

endpackage
`default_nettype wire

// File: rtl/ldpc_enc_if.sv
`default_nettype none
// ============================================================================
// Module  : ldpc_enc_if
// Purpose : Info-block input stream and codeword-block output stream.
// Revision: 1.0 - initial release
// ============================================================================
interface ldpc_enc_if #(
    parameter int D = 24
);
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/ldpc_cshift.sv
`default_nettype none
// ============================================================================
// Module  : ldpc_cshift
// Purpose : Combinational cyclic shift out[k] = in[(k+s) mod D]; a negative
//           entry yields the zero block. LDPC_ENC_SHIFT_SCALE_EN selects
//           floor(s*D/96) scaling instead of s mod D.
// Revision: 1.0 - initial release
// ============================================================================
module ldpc_cshift
    import ldpc_enc_pkg::*;
#(
    parameter int D      = 24,
    parameter int data_w = 12
) (
    input  wire logic [D-1:0]             i_data,
    input  wire logic signed [data_w-1:0] i_shift,
    output logic [D-1:0]                  o_data
);
    localparam int IW = (D > 1) ? $clog2(D) : 1;

    logic [31:0]   w_s;
    logic [31:0]   w_eff;
    logic [IW-1:0] w_idx;

    always_comb begin
        w_s = 32'($unsigned(i_shift));
`ifdef LDPC_ENC_SHIFT_SCALE_EN
        // Final mod keeps out-of-table shifts inside the rotation range.
        w_eff = ((w_s * 32'(D)) / 32'(Z0)) % 32'(D);
`else
        w_eff = w_s % 32'(D);
`endif
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < D; k++) begin
            w_idx     = IW'((32'(k) + w_eff) % 32'(D));
            o_data[k] = i_data[w_idx];
        end
        if (i_shift[data_w-1]) begin
            o_data = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ldpc_enc.sv
`default_nettype none
// ============================================================================
// Module  : ldpc_enc
// Purpose : QC-LDPC encoder for dual-diagonal (WiMax style) base matrices.
//           Optional macro: LDPC_ENC_SHIFT_SCALE_EN (shift scaling from Z0).
// Revision: 1.0 - initial release
// ============================================================================
module ldpc_enc
    import ldpc_enc_pkg::*;
#(
    parameter int C      = 12,
    parameter int R      = 24,
    parameter int D      = 24,
    parameter int data_w = 12
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic [C*R*data_w-1:0]   m,
    ldpc_enc_if.slave                    bus,
    output logic [1:0]                   status
);
    localparam int K     = R - C;
    localparam int CNT_W = $clog2(R + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;     // load beat, parity row or output beat
    logic [D-1:0]        r_u      [K];
    logic [D-1:0]        r_lambda [C];
    logic [D-1:0]        r_p      [C];
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_last;
    logic [D-1:0]        r_out_data;
    logic [1:0]          r_status;

    logic                     w_accept;
    logic [D-1:0]             w_ld_rot [C];
    logic [D-1:0]             w_lam_xor;
    logic signed [data_w-1:0] w_par_sh;
    logic [D-1:0]             w_par_rot;
    logic [D-1:0]             w_lam_sel;
    logic [D-1:0]             w_p_prev;
    logic [D-1:0]             w_p_next;
    logic [CNT_W-1:0]         w_nb;
    logic [D-1:0]             w_next_word;
    logic                     w_unused_m;

    // Staircase columns are implied by the structure, so parts of m are never read.
    assign w_unused_m = ^m;
    assign w_accept   = r_in_ready && bus.in_valid;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_data;
    assign status        = r_status;

    generate
        for (genvar gr = 0; gr < C; gr++) begin : g_row
            logic signed [data_w-1:0] w_sel;
            always_comb begin
                w_sel = '0;
                for (int c = 0; c < K; c++) begin
                    if (r_cnt == CNT_W'(c)) begin
                        w_sel = m[(C*R-1-(gr*R+c))*data_w +: data_w];
                    end
                end
            end
            ldpc_cshift #(.D(D), .data_w(data_w)) u_cshift (
                .i_data  (bus.in_data),
                .i_shift (w_sel),
                .o_data  (w_ld_rot[gr])
            );
        end
    endgenerate

    ldpc_cshift #(.D(D), .data_w(data_w)) u_cshift_p0 (
        .i_data  (r_p[0]),
        .i_shift (w_par_sh),
        .o_data  (w_par_rot)
    );

    always_comb begin
        w_lam_xor = '0;
        for (int r = 0; r < C; r++) begin
            w_lam_xor ^= r_lambda[r];
        end
        w_par_sh  = '0;
        w_lam_sel = '0;
        w_p_prev  = '0;
        for (int i = 0; i < C-1; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_par_sh  = m[(C*R-1-(i*R+K))*data_w +: data_w];
                w_lam_sel = r_lambda[i];
                if (i > 0) w_p_prev = r_p[i];
            end
        end
        w_p_next    = w_lam_sel ^ w_p_prev ^ w_par_rot;
        w_nb        = r_cnt + CNT_W'(1);
        w_next_word = '0;
        for (int j = 0; j < K; j++) begin
            if (w_nb == CNT_W'(j)) w_next_word = r_u[j];
        end
        for (int i = 0; i < C; i++) begin
            if (w_nb == CNT_W'(K + i)) w_next_word = r_p[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_status    <= ST_IDLE;
            for (int j = 0; j < K; j++) r_u[j] <= '0;
            for (int r = 0; r < C; r++) begin
                r_lambda[r] <= '0;
                r_p[r]      <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        for (int j = 0; j < K; j++) begin
                            if (r_cnt == CNT_W'(j)) r_u[j] <= bus.in_data;
                        end
                        for (int r = 0; r < C; r++) begin
                            r_lambda[r] <= r_lambda[r] ^ w_ld_rot[r];
                        end
                        if (r_cnt == CNT_W'(K - 1)) begin
                            r_state    <= S_PAR0;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_status   <= ST_PAR;
                        end else begin
                            r_state    <= S_LOAD;
                            r_cnt      <= r_cnt + CNT_W'(1);
                            r_status   <= ST_LOAD;
                        end
                    end
                end
                S_PAR0: begin
                    r_p[0] <= w_lam_xor;
                    r_cnt  <= '0;
                    if (C > 1) begin
                        r_state <= S_PARI;
                    end else begin
                        r_state     <= S_OUT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_u[0];
                        r_out_last  <= (R == 1);
                        r_status    <= ST_OUT;
                    end
                end
                S_PARI: begin
                    for (int i = 0; i < C-1; i++) begin
                        if (r_cnt == CNT_W'(i)) r_p[i+1] <= w_p_next;
                    end
                    if (r_cnt == CNT_W'(C - 2)) begin
                        r_state     <= S_OUT;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_u[0];
                        r_out_last  <= (R == 1);
                        r_status    <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        if (r_out_last) begin
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_in_ready  <= 1'b1;
                            r_status    <= ST_IDLE;
                            for (int r = 0; r < C; r++) r_lambda[r] <= '0;
                        end else begin
                            r_cnt      <= w_nb;
                            r_out_data <= w_next_word;
                            r_out_last <= (w_nb == CNT_W'(R - 1));
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_enc.sv
`default_nettype none
// ============================================================================
// Module  : tb_ldpc_enc
// Purpose : Self-checking bench for ldpc_enc with the WiMax rate-1/2 matrix.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ldpc_enc;
    localparam int C  = 12;
    localparam int R  = 24;
    localparam int D  = 24;
    localparam int DW = 12;
    localparam int K  = R - C;

    logic              clk = 1'b0;
    logic              rst;
    logic [C*R*DW-1:0] m;
    logic [1:0]        status;

    int total = 0;
    int bad   = 0;

    ldpc_enc_if #(.D(D)) bus();

    ldpc_enc #(.C(C), .R(R), .D(D), .data_w(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .m      (m),
        .bus    (bus),
        .status (status)
    );

    always #5 clk = ~clk;

    // IEEE 802.16e rate-1/2 base matrix, shifts given for Z0 = 96.
    int H [C][R] = '{
        '{-1,94,73,-1,-1,-1,-1,-1,55,83,-1,-1, 7, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1},
        '{-1,27,-1,-1,-1,22,79, 9,-1,-1,-1,12,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1},
        '{-1,-1,-1,24,22,81,-1,33,-1,-1,-1, 0,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1},
        '{61,-1,47,-1,-1,-1,-1,-1,65,25,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1},
        '{-1,-1,39,-1,-1,-1,84,-1,-1,41,72,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1},
        '{-1,-1,-1,-1,46,40,-1,82,-1,-1,-1,79, 0,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1},
        '{-1,-1,95,53,-1,-1,-1,-1,-1,14,18,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1},
        '{-1,11,73,-1,-1,-1, 2,-1,-1,47,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1},
        '{12,-1,-1,-1,83,24,-1,43,-1,-1,-1,51,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1},
        '{-1,-1,-1,-1,-1,94,-1,59,-1,-1,70,72,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1},
        '{-1,-1, 7,65,-1,-1,-1,-1,39,49,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0},
        '{43,-1,-1,-1,-1,66,-1,41,-1,-1,-1,26, 7,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0}
    };

    typedef struct {
        logic [D-1:0] u0;
        logic [D-1:0] urest;
        int           gap;
        int           stall_beat;
        int           stall_len;
        bit           exp_zero;
    } vec_t;

    vec_t         vecs [4];
    logic [D-1:0] info [K];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [D-1:0] pshift(input logic [D-1:0] u, input int s);
        int           e;
        logic [D-1:0] v;
        if (s < 0) return '0;
`ifdef LDPC_ENC_SHIFT_SCALE_EN
        e = (s * D) / 96;
`else
        e = s % D;
`endif
        for (int k = 0; k < D; k++) v[k] = u[(k + e) % D];
        return v;
    endfunction

    // Reference: systematic codeword whose syndrome H*c is zero in every row.
    task automatic run_frame(input logic [D-1:0] inf [K], input int gap,
                             input int stall_beat, input int stall_len, input bit exp_zero);
        logic [D-1:0] cw [R];
        logic [D-1:0] syn;
        logic [D-1:0] held;
        int           lat;
        int           b;
        int           guard;
        bit           stalled;
        for (int j = 0; j < K; j++) begin
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = D'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = inf[j];
            guard = 0;
            while (!bus.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = D'($urandom);
        check("in_ready_after_load", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("out_valid_latency", 32'(lat), 32'(C));
        b       = 0;
        guard   = 0;
        stalled = 1'b0;
        bus.out_ready = 1'b1;
        while (b < R && guard < 200) begin
            guard++;
            if (bus.out_valid) begin
                if (b == stall_beat && !stalled) begin
                    stalled       = 1'b1;
                    held          = bus.out_data;
                    bus.out_ready = 1'b0;
                    for (int s = 0; s < stall_len; s++) begin
                        @(negedge clk);
                        check("stall_hold", 32'(bus.out_data), 32'(held));
                        check("stall_valid", 32'(bus.out_valid), 32'd1);
                    end
                    bus.out_ready = 1'b1;
                end
                cw[b] = bus.out_data;
                check($sformatf("out_last_b%0d", b), 32'(bus.out_last), 32'(b == R-1));
                check("in_ready_during_out", 32'(bus.in_ready), 32'd0);
                b++;
            end
            @(negedge clk);
        end
        check("beat_count", 32'(b), 32'(R));
        check("in_ready_after_last", 32'(bus.in_ready), 32'd1);
        check("status_after_last", 32'(status), 32'd0);
        check("out_valid_after_last", 32'(bus.out_valid), 32'd0);
        for (int j = 0; j < K; j++) begin
            check($sformatf("info_echo_b%0d", j), 32'(cw[j]), 32'(inf[j]));
        end
        for (int r = 0; r < C; r++) begin
            syn = '0;
            for (int c = 0; c < R; c++) begin
                if (H[r][c] >= 0) syn ^= pshift(cw[c], H[r][c]);
            end
            check($sformatf("syndrome_row%0d", r), 32'(syn), 32'd0);
        end
        if (exp_zero) begin
            for (int j = K; j < R; j++) begin
                check($sformatf("zero_parity_b%0d", j), 32'(cw[j]), 32'd0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < C; r++) begin
            for (int c = 0; c < R; c++) begin
                m[(C*R-1-(r*R+c))*DW +: DW] = DW'(H[r][c]);
            end
        end
        vecs[0] = '{24'h000000, 24'h000000, 0, -1, 0, 1'b1};
        vecs[1] = '{24'h000001, 24'h000000, 0, -1, 0, 1'b0};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1, -1, 0, 1'b0};
        vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 0,  3, 5, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_status", 32'(status), 32'd0);

        for (int v = 0; v < 4; v++) begin
            info[0] = vecs[v].u0;
            for (int j = 1; j < K; j++) info[j] = vecs[v].urest;
            run_frame(info, vecs[v].gap, vecs[v].stall_beat, vecs[v].stall_len, vecs[v].exp_zero);
        end

        // Abort a frame after five beats, then encode a fresh one.
        for (int j = 0; j < 5; j++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = D'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        check("midframe_status_load", 32'(status), 32'd1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_status", 32'(status), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < K; j++) info[j] = D'($urandom);
        run_frame(info, 0, -1, 0, 1'b0);

        for (int f = 0; f < 20; f++) begin
            for (int j = 0; j < K; j++) info[j] = D'($urandom);
            run_frame(info, int'($urandom_range(0, 1)), int'($urandom_range(0, R-1)),
                      int'($urandom_range(1, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
